i2c_target_responder: RTL and testbench
=======================================

Name: i2c_target_responder

Overview:
- I2C target (slave) for the FPGA fabric: the responder end of the bit-banged I2C master bus.
- Emulates a BMP280-style device at 7-bit address 0x77 (address byte 0xEE for write, 0xEF for read).
- Decodes START, address, register pointer, write data and read data on the FPGA_CLK1_50 domain.
- Serves a read-only chip-ID register and a 16-entry read/write register bank so master sequences can be exercised on-chip without a sensor.

Parameters:
- DEV_ADDR, 7'h77, 7-bit target address.
- CHIP_ID_ADDR, 8'hD0, register address of the read-only chip ID.
- CHIP_ID, 8'h58, value returned at CHIP_ID_ADDR.
- BANK_BASE, 8'hF0, base of the 16-entry R/W bank (BANK_BASE..BANK_BASE+15, base 16-aligned).

Ports:
- FPGA_CLK1_50 in 1: system clock; all logic is on this clock.
- reset in 1: asynchronous, active-high reset.
- scl_in in 1: raw bus SCL (asynchronous to the clock).
- sda_in in 1: raw bus SDA (asynchronous to the clock).
- sda_oe out 1: 1 pulls SDA low; 0 releases SDA (open drain).
- wr_strobe out 1: one-cycle pulse when a data byte is written to the bank.
- wr_addr out 8: register address of that write.
- wr_data out 8: data byte of that write.
- busy out 1: high from an addressed START until STOP.

Behaviour:
- Reset values: sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0. Pointer=0x00, bank all 0x00, state=IDLE.
- Synchronisers: scl_in and sda_in each pass through a 2-FF synchroniser plus a previous-value FF.
  - Rise and fall edge pulses come from the synchronised values.
  - Bus-to-internal latency is 2 cycles.
- Bus conditions:
  - START/Sr: SDA fall while SCL high. Effect: state=ADDR, bit count=0, sda_oe=0, from any state.
  - STOP: SDA rise while SCL high. Effect: state=IDLE, sda_oe=0, busy=0, from any state.
- Timing rules: sample SDA on SCL rise. Change sda_oe only on SCL fall. sda_oe never changes while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR:
  - Shift 8 bits MSB first.
  - After the 8th rise, compare bits[7:1] to DEV_ADDR.
  - Mismatch: go to IGNORE. sda_oe stays 0 until the next START.
  - Match: busy=1. On the next SCL fall set sda_oe=1 and go to ADDR_ACK. Latch the R/W bit.
- ADDR_ACK:
  - On the next SCL fall, release the ACK.
  - R/W=0: go to PTR.
  - R/W=1: go to RDATA. On that same fall, load the read byte at the pointer and drive its MSB (sda_oe = ~bit7).
- PTR: receive 8 bits into the pointer. ACK as above. After the ACK fall, go to WDATA.
- WDATA:
  - Receive 8 bits, then ACK.
  - On the 8th rise: if pointer is in the bank, write the bank entry and pulse wr_strobe with wr_addr=pointer and wr_data=byte.
  - Then pointer = pointer+1, wrapping mod 256.
  - Writes to CHIP_ID_ADDR or unmapped addresses: ACKed and pointer incremented, but no write and no strobe.
- RDATA:
  - Drive bits 6..0 on successive SCL falls.
  - After the 8th bit's fall, release SDA (sda_oe=0) and go to RDATA_ACK.
- Read value by pointer: CHIP_ID_ADDR returns CHIP_ID; bank addresses return the bank entry; all others return 0x00.
- RDATA_ACK:
  - On SCL rise, sample master ACK.
  - SDA=0 (ACK): pointer+1 (wraps), load the next byte, drive its MSB on the next fall.
  - SDA=1 (NACK): go to IGNORE, SDA released.
- Simultaneous events:
  - START/STOP detection takes priority over bit sampling in the same cycle.
  - A wr_strobe fires only on a completed 8th rise. A STOP after fewer bits discards the partial byte.
- Reset mid-transfer: SDA is released immediately (asynchronous). The bank clears.

Test Plan:
- Write 0xEE, ptr 0xF3, data 0xA5, STOP -> ACK on all 3 bytes; one wr_strobe with wr_addr=0xF3, wr_data=0xA5; busy low after STOP.
- Write 0xEE, ptr 0xD0, Sr, 0xEF, master NACK -> read byte 0x58 MSB first; SDA released on the 9th clock; state IGNORE until STOP.
- Burst write from ptr 0xFE of 0x11, 0x22, 0x33 -> strobes at 0xFE and 0xFF; pointer wraps; 0x00 write ACKed, no strobe. Then a burst read from 0xFE with ACK, ACK, NACK -> 0x11, 0x22, 0x00.
- Address 0xEC (0x76) -> sda_oe stays 0 for the whole frame; busy=0; no strobe.
- STOP after 4 data bits -> no strobe; sda_oe=0. reset asserted mid read byte -> sda_oe=0 within the same cycle; reading 0xF3 afterwards returns 0x00.
- Assertion throughout all tests -> sda_oe never toggles while synchronised SCL is high.

Source files
------------

// File: rtl/i2c_target_responder_if.sv
// I2C target bus bundle.
// Purpose: groups the raw bus inputs and the target's outputs so the
// responder and its environment share one connection point.
// Signals:
//   scl_in, sda_in : raw bus lines (asynchronous to the system clock)
//   sda_oe         : 1 pulls SDA low, 0 releases it (open drain)
//   wr_strobe      : one-cycle pulse per byte written into the bank
//   wr_addr/wr_data: register address and data of that write
//   busy           : high from an addressed START until STOP
`timescale 1ns/1ps
interface i2c_target_responder_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, wr_strobe, wr_addr, wr_data, busy
  );

  modport master (
    output scl_in, sda_in,
    input  sda_oe, wr_strobe, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target emulating a BMP280-style device for exercising an on-chip
// I2C master. Answers at DEV_ADDR, serves a read-only chip ID and a
// 16-entry read/write register bank with an auto-incrementing pointer.
// Ports:
//   FPGA_CLK1_50 : system clock, all logic runs on it
//   reset        : asynchronous, active-high
//   bus          : slave side of i2c_target_responder_if (scl_in/sda_in in;
//                  sda_oe, wr_strobe, wr_addr, wr_data, busy out)
`timescale 1ns/1ps
module i2c_target_responder #(
  parameter logic [6:0] DEV_ADDR     = 7'h77,
  parameter logic [7:0] CHIP_ID_ADDR = 8'hD0,
  parameter logic [7:0] CHIP_ID      = 8'h58,
  parameter logic [7:0] BANK_BASE    = 8'hF0
) (
  input  logic FPGA_CLK1_50,
  input  logic reset,
  i2c_target_responder_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK,
    RDATA, RDATA_ACK, IGNORE
  } state_t;

  function automatic logic in_bank(input logic [7:0] a);
    return a[7:4] == BANK_BASE[7:4];
  endfunction

  function automatic logic [7:0] read_value(input logic [7:0] a,
                                            input logic [7:0] entry);
    if (a == CHIP_ID_ADDR) return CHIP_ID;
    else if (in_bank(a))   return entry;
    else                   return 8'h00;
  endfunction

  // Synchronisers: two flops per line plus a previous-value flop for edges.
  // Reset to the idle-bus level so leaving reset never looks like an edge.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[0], bus.sda_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  assign sda_rise  =  sda_s & ~sda_prev_q;
  assign sda_fall  = ~sda_s &  sda_prev_q;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic       rw_q, rw_d, ack_due_q, ack_due_d, sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [7:0] bank_q [16];
  logic       bank_we;
  logic [7:0] shift_nx, ptr_inc, rd_cur, rd_nxt;

  assign shift_nx = {shift_q[6:0], sda_s};
  assign ptr_inc  = ptr_q + 8'd1;
  assign rd_cur   = read_value(ptr_q,   bank_q[ptr_q[3:0]]);
  assign rd_nxt   = read_value(ptr_inc, bank_q[ptr_inc[3:0]]);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_due_d   = ack_due_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    bank_we     = 1'b0;

    // Bus conditions override whatever bit-level work this cycle would do.
    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_due_d = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bitcnt_d  = 4'd0;
      sda_oe_d  = 1'b0;
      ack_due_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, PTR, WDATA: begin
          // After the 8th rise the ACK is owed but only driven on the next
          // fall, so SDA never moves while SCL is high.
          if (ack_due_q) begin
            if (scl_fall) begin
              sda_oe_d  = 1'b1;
              ack_due_d = 1'b0;
              state_d   = (state_q == ADDR) ? ADDR_ACK :
                          (state_q == PTR)  ? PTR_ACK  : WDATA_ACK;
            end
          end else if (scl_rise) begin
            shift_d  = shift_nx;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d  = 4'd0;
              ack_due_d = 1'b1;
              if (state_q == ADDR) begin
                if (shift_nx[7:1] == DEV_ADDR) begin
                  busy_d = 1'b1;
                  rw_d   = shift_nx[0];
                end else begin
                  ack_due_d = 1'b0;
                  state_d   = IGNORE;
                end
              end else if (state_q == PTR) begin
                ptr_d = shift_nx;
              end else begin
                if (in_bank(ptr_q)) begin
                  bank_we     = 1'b1;
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = ptr_q;
                  wr_data_d   = shift_nx;
                end
                ptr_d = ptr_inc;
              end
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (rw_q) begin
            state_d  = RDATA;
            tx_d     = rd_cur;
            sda_oe_d = ~rd_cur[7];
            bitcnt_d = 4'd1;
          end else begin
            state_d  = PTR;
            sda_oe_d = 1'b0;
            bitcnt_d = 4'd0;
          end
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          state_d  = WDATA;
          sda_oe_d = 1'b0;
          bitcnt_d = 4'd0;
        end
        RDATA: if (scl_fall) begin
          // bitcnt counts bits already driven; the fall after bit 0 releases.
          if (bitcnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = RDATA_ACK;
          end else begin
            sda_oe_d = ~tx_q[3'd7 - bitcnt_q[2:0]];
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
        RDATA_ACK: if (scl_rise) begin
          if (!sda_s) begin
            ptr_d    = ptr_inc;
            tx_d     = rd_nxt;
            bitcnt_d = 4'd0;
            state_d  = RDATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= 4'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      ptr_q       <= 8'h00;
      rw_q        <= 1'b0;
      ack_due_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_due_q   <= ack_due_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) bank_q[i] <= 8'h00;
    end else if (bank_we) begin
      bank_q[ptr_q[3:0]] <= shift_nx;
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.busy      = busy_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
`timescale 1ns/1ps
module tb_i2c_target_responder;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  always #10 clk = ~clk;

  i2c_target_responder_if bus ();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;   // wired-AND open-drain line

  i2c_target_responder dut (.FPGA_CLK1_50(clk), .reset(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Write monitor.
  int         strobe_cnt = 0;
  logic [7:0] last_waddr = 8'h00;
  logic [7:0] last_wdata = 8'h00;
  always @(posedge clk) if (bus.wr_strobe) begin
    strobe_cnt <= strobe_cnt + 1;
    last_waddr <= bus.wr_addr;
    last_wdata <= bus.wr_data;
  end

  // sda_oe must hold steady while the synchronised SCL is high.
  logic [1:0] scl_sync_tb = 2'b11;
  logic       oe_last = 1'b0;
  int         viol = 0;
  int         oe_cycles = 0;
  always @(posedge clk) scl_sync_tb <= {scl_sync_tb[0], scl_m};
  always @(negedge clk) begin
    if (!rst && (oe_last !== bus.sda_oe) && scl_sync_tb[1]) viol <= viol + 1;
    oe_last   <= bus.sda_oe;
    oe_cycles <= oe_cycles + (bus.sda_oe ? 1 : 0);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; cyc(H);
    scl_m = 1'b1; cyc(H);
    sda_m = 1'b0; cyc(H);
    scl_m = 1'b0; cyc(H);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; cyc(H);
    scl_m = 1'b1; cyc(H);
    sda_m = 1'b1; cyc(H);
  endtask

  task automatic clock_bit(input logic b, output logic seen, output logic oe);
    sda_m = b;    cyc(H);
    scl_m = 1'b1; cyc(H/2);
    seen = bus.sda_in;
    oe   = bus.sda_oe;
    cyc(H/2);
    scl_m = 1'b0; cyc(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s, o);
    clock_bit(1'b1, s, o);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b, output logic oe9);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s, o);
      b[i] = s;
    end
    clock_bit(~mack, s, o);
    oe9 = o;
  endtask

  typedef struct packed {
    logic [7:0] ptr;
    logic [7:0] data;
    logic       strobe;
    logic [7:0] rd;
  } vec_t;

  initial begin
    vec_t       vt [6];
    logic       a0, a1, a2, a3, a4, o9;
    logic       s, o;
    logic [7:0] b;
    int         s0, e0;

    vt[0] = '{ptr: 8'hF3, data: 8'hA5, strobe: 1'b1, rd: 8'hA5};
    vt[1] = '{ptr: 8'hF0, data: 8'h01, strobe: 1'b1, rd: 8'h01};
    vt[2] = '{ptr: 8'hFF, data: 8'h80, strobe: 1'b1, rd: 8'h80};
    vt[3] = '{ptr: 8'hD0, data: 8'h12, strobe: 1'b0, rd: 8'h58};
    vt[4] = '{ptr: 8'h10, data: 8'h34, strobe: 1'b0, rd: 8'h00};
    vt[5] = '{ptr: 8'hF3, data: 8'h5A, strobe: 1'b1, rd: 8'h5A};

    // Reset state
    cyc(3);
    check("rst_sda_oe",    {31'd0, bus.sda_oe},    32'd0);
    check("rst_wr_strobe", {31'd0, bus.wr_strobe}, 32'd0);
    check("rst_wr_addr",   {24'd0, bus.wr_addr},   32'd0);
    check("rst_wr_data",   {24'd0, bus.wr_data},   32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    rst = 1'b0;
    cyc(H);

    // Single-byte write then read-back per vector
    for (int i = 0; i < 6; i++) begin
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'hEE, a0);
      write_byte(vt[i].ptr, a1);
      write_byte(vt[i].data, a2);
      i2c_stop();
      check($sformatf("v%0d_acks", i), {29'd0, a0, a1, a2}, 32'h7);
      check($sformatf("v%0d_strobes", i), strobe_cnt - s0, {31'd0, vt[i].strobe});
      if (vt[i].strobe) begin
        check($sformatf("v%0d_waddr", i), {24'd0, last_waddr}, {24'd0, vt[i].ptr});
        check($sformatf("v%0d_wdata", i), {24'd0, last_wdata}, {24'd0, vt[i].data});
      end
      check($sformatf("v%0d_busy_after_stop", i), {31'd0, bus.busy}, 32'd0);
      i2c_start();
      write_byte(8'hEE, a0);
      write_byte(vt[i].ptr, a1);
      i2c_start();
      write_byte(8'hEF, a2);
      read_byte(1'b0, b, o9);
      i2c_stop();
      check($sformatf("v%0d_rd_acks", i), {29'd0, a0, a1, a2}, 32'h7);
      check($sformatf("v%0d_rd", i), {24'd0, b}, {24'd0, vt[i].rd});
    end

    // Chip-ID read with NACK, then the target stays quiet until STOP
    i2c_start();
    write_byte(8'hEE, a0);
    write_byte(8'hD0, a1);
    i2c_start();
    write_byte(8'hEF, a2);
    check("id_busy_mid", {31'd0, bus.busy}, 32'd1);
    read_byte(1'b0, b, o9);
    check("id_value", {24'd0, b}, 32'h58);
    check("id_oe_9th", {31'd0, o9}, 32'd0);
    e0 = oe_cycles;
    read_byte(1'b0, b, o9);
    check("id_ignore_byte", {24'd0, b}, 32'hFF);
    check("id_ignore_oe", oe_cycles - e0, 32'd0);
    check("id_busy_before_stop", {31'd0, bus.busy}, 32'd1);
    i2c_stop();
    check("id_busy_after_stop", {31'd0, bus.busy}, 32'd0);

    // Burst write across the pointer wrap, then burst read back
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hEE, a0);
    write_byte(8'hFE, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    write_byte(8'h33, a4);
    i2c_stop();
    check("burst_acks", {27'd0, a0, a1, a2, a3, a4}, 32'h1F);
    check("burst_strobes", strobe_cnt - s0, 32'd2);
    check("burst_last_waddr", {24'd0, last_waddr}, 32'hFF);
    check("burst_last_wdata", {24'd0, last_wdata}, 32'h22);
    i2c_start();
    write_byte(8'hEE, a0);
    write_byte(8'hFE, a1);
    i2c_start();
    write_byte(8'hEF, a2);
    read_byte(1'b1, b, o9);
    check("burst_rd0", {24'd0, b}, 32'h11);
    read_byte(1'b1, b, o9);
    check("burst_rd1", {24'd0, b}, 32'h22);
    read_byte(1'b0, b, o9);
    check("burst_rd2", {24'd0, b}, 32'h00);
    i2c_stop();

    // Wrong address: never drives SDA, never busy, no write
    s0 = strobe_cnt;
    e0 = oe_cycles;
    i2c_start();
    write_byte(8'hEC, a0);
    check("badaddr_busy", {31'd0, bus.busy}, 32'd0);
    write_byte(8'h55, a1);
    i2c_stop();
    check("badaddr_acks", {30'd0, a0, a1}, 32'd0);
    check("badaddr_oe", oe_cycles - e0, 32'd0);
    check("badaddr_strobes", strobe_cnt - s0, 32'd0);

    // STOP after 4 data bits discards the partial byte
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hEE, a0);
    write_byte(8'hF3, a1);
    clock_bit(1'b1, s, o);
    clock_bit(1'b0, s, o);
    clock_bit(1'b1, s, o);
    clock_bit(1'b0, s, o);
    i2c_stop();
    check("partial_strobes", strobe_cnt - s0, 32'd0);
    check("partial_oe", {31'd0, bus.sda_oe}, 32'd0);
    check("partial_busy", {31'd0, bus.busy}, 32'd0);
    i2c_start();
    write_byte(8'hEE, a0);
    write_byte(8'hF3, a1);
    i2c_start();
    write_byte(8'hEF, a2);
    read_byte(1'b0, b, o9);
    i2c_stop();
    check("partial_readback", {24'd0, b}, 32'h5A);

    // Reset while the target is driving a read bit low
    i2c_start();
    write_byte(8'hEE, a0);
    write_byte(8'hF3, a1);
    i2c_start();
    write_byte(8'hEF, a2);
    check("rdrst_driving", {31'd0, bus.sda_oe}, 32'd1);
    #2 rst = 1'b1;
    #1 check("rdrst_oe_async", {31'd0, bus.sda_oe}, 32'd0);
    cyc(3);
    sda_m = 1'b1;
    scl_m = 1'b1;
    cyc(H);
    rst = 1'b0;
    cyc(H);
    i2c_start();
    write_byte(8'hEE, a0);
    write_byte(8'hF3, a1);
    i2c_start();
    write_byte(8'hEF, a2);
    read_byte(1'b0, b, o9);
    i2c_stop();
    check("rdrst_acks", {29'd0, a0, a1, a2}, 32'h7);
    check("rdrst_bank_cleared", {24'd0, b}, 32'h00);

    cyc(2);
    check("oe_stable_scl_high", viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
